sort_frame_ctrl: RTL and testbench
==================================

# sort_frame_ctrl

Frame sequencer for the LLR insertion-sort chain in the NB-LDPC check-node path. Accepts a frame of candidate entries (LLR, Q, IndexA, IndexI) over a valid/ready stream and clears the sort chain at the start of each frame. Feeds one entry per cycle into the chain, waits out the chain's pipeline latency, then drains the Out_Num best entries (smallest LLR first) to the downstream consumer over a second valid/ready stream.

## Interface
- LLR_Width, 5, MSB index of LLR fields (field is LLR_Width+1 bits)
- Q_Width, 6, MSB index of Q fields
- IndexA_Width, 5, MSB index of IndexA fields
- IndexI_Width, 5, MSB index of IndexI fields
- Frame_Len, 32, maximum candidates per frame (≥2)
- Out_Num, 16, sorted entries drained per frame (1..Frame_Len)
- Flush_Cycles, 2, sort-chain latency from last sort_en to stable head (≥1)

- clk  in  1  clock; all state changes on rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid / in_ready  in / out  1  candidate handshake
- in_last  in  1  last candidate of frame
- in_LLR, in_Q, in_IndexA, in_IndexI  in  field widths  candidate
- sort_clear  out  1  initialise chain to empty (max LLR)
- sort_en  out  1  chain captures sort_* this cycle
- sort_LLR, sort_Q, sort_IndexA, sort_IndexI  out  field widths  registered candidate to chain
- sort_shift  out  1  pop chain head, advance list by one
- head_LLR, head_Q, head_IndexA, head_IndexI  in  field widths  current chain head (best entry)
- out_valid / out_ready  out / in  1  sorted-output handshake
- out_LLR, out_Q, out_IndexA, out_IndexI  out  field widths  equal head_* (combinational pass-through)
- out_last  out  1  marks Out_Num-th entry
- frame_err  out  1  one-cycle pulse on frame-length mismatch

## Operation
- States: IDLE, CLEAR, LOAD, FLUSH, DRAIN.
- IDLE: in_ready=0. Go to CLEAR when in_valid=1.
- CLEAR: one cycle with sort_clear=1. Input count is zeroed. Go to LOAD.
- LOAD: in_ready=1. On each accept, register the fields into sort_*, set sort_en=1 for the following cycle, and increment the count.
- Frame end in LOAD is the accept with in_last=1, or the accept with count=Frame_Len-1, whichever comes first. On frame end go to FLUSH.
- frame_err pulses in the cycle after frame end if in_last and (count=Frame_Len-1) disagree. The frame is still processed.
- FLUSH: counts Flush_Cycles cycles, then goes to DRAIN. in_ready=0.
- DRAIN: out_valid=1. On out_valid&out_ready, sort_shift=1 in the same cycle and the output count increments. out_last=1 when output count=Out_Num-1. The accept with out_last goes to CLEAR if in_valid=1, else to IDLE.
- If a frame has fewer than Out_Num candidates, drain still emits Out_Num entries; the tail entries carry the chain's cleared value (all-ones LLR).
- Counters: $clog2(Frame_Len) bits for input, $clog2(Out_Num) bits for output, $clog2(Flush_Cycles+1) bits for flush. No wrap is possible because the terminal counts force a state change.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE; all counters 0.
  - in_ready, sort_clear, sort_en, sort_shift, out_valid, out_last and frame_err are 0.
  - sort_* are 0.
  - A frame in progress is discarded.
- Back-to-back frame of N candidates, first accept at edge t:
  - sort_en is high during cycles t+1..t+N.
  - FLUSH occupies cycles t+N..t+N+Flush_Cycles-1, overlapping the final sort_en cycle.
  - out_valid first rises in cycle t+N+Flush_Cycles.
- Drain throughput is one entry per cycle while out_ready=1. out_* and out_last must hold stable while out_valid=1 and out_ready=0.
- At most one sort_en and one sort_shift per cycle; they are never asserted together. sort_clear is never asserted together with either.
- Minimum turnaround between frames is one CLEAR cycle; the bubble is 1 cycle.

## Structure
- Shared package sort_pkg holds:
  - field width constants;
  - the entry struct typedef {LLR, Q, IndexA, IndexI};
  - the state enum;
  - the LLR_MAX constant for the cleared value.
- No sub-module: the FSM, three counters and the input register fit in a single module. The sort chain is instantiated alongside by the parent, not inside this block.

## Test plan
- Reset then a 32-entry frame with LLRs 31..0, out_ready=1:
  - sort_en is high for 32 cycles;
  - out_valid rises 2 cycles after the last sort_en;
  - the output LLR sequence is 0..15;
  - out_last is high on LLR 15.
- 10-entry frame with in_last on entry 10, Out_Num=16:
  - frame_err pulses once;
  - 16 outputs, the last 6 with LLR=63.
- in_valid toggled randomly in LOAD and out_ready toggled randomly in DRAIN: no entry is lost or duplicated, and out_* hold while stalled.
- Two frames back-to-back with in_valid held high: exactly one CLEAR cycle between the last out_last accept and the next in_ready.
- reset_n asserted mid-LOAD (after 7 accepts) and mid-DRAIN (after 3 outputs): all outputs are 0 immediately. The next frame is sorted correctly with no carry-over.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and constants for the LLR sort-chain frame sequencer.
// Holds field widths (each value is the MSB index of its field), the
// candidate entry struct, the sequencer state enum and the cleared LLR value.
package sort_pkg;

  localparam int LLR_Width    = 5;
  localparam int Q_Width      = 6;
  localparam int IndexA_Width = 5;
  localparam int IndexI_Width = 5;

  typedef struct packed {
    logic [LLR_Width:0]    llr;
    logic [Q_Width:0]      q;
    logic [IndexA_Width:0] idx_a;
    logic [IndexI_Width:0] idx_i;
  } entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  // Value a cleared chain slot holds: worst possible LLR.
  localparam logic [LLR_Width:0] LLR_MAX = '1;

  // Counter width that stays at least one bit for degenerate counts.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_frame_ctrl.sv
// Frame sequencer for the LLR insertion-sort chain: clears the chain, loads one
// candidate per cycle, waits Flush_Cycles for the chain to settle, then drains
// the Out_Num best entries.
// Ports: in_* candidate stream (valid/ready, in_last), sort_* chain controls and
// registered candidate, head_* chain head, out_* sorted stream (valid/ready,
// out_last), frame_err one-cycle pulse on frame-length mismatch.
module sort_frame_ctrl
  import sort_pkg::*;
#(
  parameter int Frame_Len    = 32,
  parameter int Out_Num      = 16,
  parameter int Flush_Cycles = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // candidate input stream
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [LLR_Width:0]      in_LLR,
  input  logic [Q_Width:0]        in_Q,
  input  logic [IndexA_Width:0]   in_IndexA,
  input  logic [IndexI_Width:0]   in_IndexI,
  // sort chain control
  output logic                    sort_clear,
  output logic                    sort_en,
  output logic [LLR_Width:0]      sort_LLR,
  output logic [Q_Width:0]        sort_Q,
  output logic [IndexA_Width:0]   sort_IndexA,
  output logic [IndexI_Width:0]   sort_IndexI,
  output logic                    sort_shift,
  // sort chain head
  input  logic [LLR_Width:0]      head_LLR,
  input  logic [Q_Width:0]        head_Q,
  input  logic [IndexA_Width:0]   head_IndexA,
  input  logic [IndexI_Width:0]   head_IndexI,
  // sorted output stream
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LLR_Width:0]      out_LLR,
  output logic [Q_Width:0]        out_Q,
  output logic [IndexA_Width:0]   out_IndexA,
  output logic [IndexI_Width:0]   out_IndexI,
  output logic                    out_last,
  output logic                    frame_err
);

  localparam int IN_W  = cnt_bits(Frame_Len);
  localparam int OUT_W = cnt_bits(Out_Num);
  localparam int FL_W  = cnt_bits(Flush_Cycles + 1);

  localparam logic [IN_W-1:0]  IN_TERM   = IN_W'(Frame_Len - 1);
  localparam logic [OUT_W-1:0] OUT_PRE   = OUT_W'(Out_Num - 2);
  localparam logic [FL_W-1:0]  FL_TERM   = FL_W'(Flush_Cycles - 1);
  localparam logic             ONE_ENTRY = (Out_Num == 1);

  state_t            state;
  logic [IN_W-1:0]   in_cnt;
  logic [OUT_W-1:0]  out_cnt;
  logic [FL_W-1:0]   fl_cnt;
  entry_t            sort_q;

  logic in_acc;
  logic cnt_term;
  logic frame_end;

  assign in_acc    = (state == ST_LOAD) && in_valid && in_ready;
  assign cnt_term  = (in_cnt == IN_TERM);
  assign frame_end = in_acc && (in_last || cnt_term);

  // The chain pops its head in the very cycle the consumer takes it, so the
  // next head is already presented on the following cycle.
  assign sort_shift = out_valid && out_ready;

  assign sort_LLR    = sort_q.llr;
  assign sort_Q      = sort_q.q;
  assign sort_IndexA = sort_q.idx_a;
  assign sort_IndexI = sort_q.idx_i;

  assign out_LLR    = head_LLR;
  assign out_Q      = head_Q;
  assign out_IndexA = head_IndexA;
  assign out_IndexI = head_IndexI;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      in_cnt     <= '0;
      out_cnt    <= '0;
      fl_cnt     <= '0;
      sort_q     <= '0;
      in_ready   <= 1'b0;
      sort_clear <= 1'b0;
      sort_en    <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // single-cycle strobes
      sort_clear <= 1'b0;
      sort_en    <= 1'b0;
      frame_err  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state      <= ST_CLEAR;
            sort_clear <= 1'b1;
          end
        end

        ST_CLEAR: begin
          in_cnt   <= '0;
          in_ready <= 1'b1;
          state    <= ST_LOAD;
        end

        ST_LOAD: begin
          if (in_acc) begin
            sort_q  <= '{llr: in_LLR, q: in_Q, idx_a: in_IndexA, idx_i: in_IndexI};
            sort_en <= 1'b1;
            if (frame_end) begin
              // Counter stops at its terminal value instead of wrapping.
              state     <= ST_FLUSH;
              in_ready  <= 1'b0;
              fl_cnt    <= '0;
              frame_err <= (in_last != cnt_term);
            end else begin
              in_cnt <= in_cnt + 1'b1;
            end
          end
        end

        ST_FLUSH: begin
          if (fl_cnt == FL_TERM) begin
            state     <= ST_DRAIN;
            out_valid <= 1'b1;
            out_cnt   <= '0;
            out_last  <= ONE_ENTRY;
          end else begin
            fl_cnt <= fl_cnt + 1'b1;
          end
        end

        ST_DRAIN: begin
          if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_cnt   <= '0;
              if (in_valid) begin
                state      <= ST_CLEAR;
                sort_clear <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              out_cnt  <= out_cnt + 1'b1;
              // out_last is registered, so it is armed one entry early.
              out_last <= (out_cnt == OUT_PRE);
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Bench for sort_frame_ctrl: a queue-based sort chain feeds head_*, a reference
// model picks the Out_Num smallest LLRs per frame into a scoreboard, and a
// negedge monitor pops and compares every accepted output.
module tb_sort_frame_ctrl;
  import sort_pkg::*;

  localparam int FL = 32;
  localparam int ON = 16;
  localparam int FC = 2;
  localparam entry_t CLEARED = '{llr: LLR_MAX, q: '0, idx_a: '0, idx_i: '0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic                  in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [LLR_Width:0]    in_LLR = '0;
  logic [Q_Width:0]      in_Q = '0;
  logic [IndexA_Width:0] in_IndexA = '0;
  logic [IndexI_Width:0] in_IndexI = '0;
  logic                  sort_clear, sort_en, sort_shift;
  logic [LLR_Width:0]    sort_LLR;
  logic [Q_Width:0]      sort_Q;
  logic [IndexA_Width:0] sort_IndexA;
  logic [IndexI_Width:0] sort_IndexI;
  entry_t                head_e = CLEARED;
  logic                  out_valid, out_ready = 1'b1, out_last, frame_err;
  logic [LLR_Width:0]    out_LLR;
  logic [Q_Width:0]      out_Q;
  logic [IndexA_Width:0] out_IndexA;
  logic [IndexI_Width:0] out_IndexI;

  sort_frame_ctrl #(.Frame_Len(FL), .Out_Num(ON), .Flush_Cycles(FC)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_LLR(in_LLR), .in_Q(in_Q), .in_IndexA(in_IndexA), .in_IndexI(in_IndexI),
    .sort_clear(sort_clear), .sort_en(sort_en),
    .sort_LLR(sort_LLR), .sort_Q(sort_Q), .sort_IndexA(sort_IndexA), .sort_IndexI(sort_IndexI),
    .sort_shift(sort_shift),
    .head_LLR(head_e.llr), .head_Q(head_e.q), .head_IndexA(head_e.idx_a), .head_IndexI(head_e.idx_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_LLR(out_LLR), .out_Q(out_Q), .out_IndexA(out_IndexA), .out_IndexI(out_IndexI),
    .out_last(out_last), .frame_err(frame_err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cycle-time %0t", nm, act, want, $time);
    end
  endtask

  // ---------------- sort chain stand-in ----------------
  entry_t chain[$];
  entry_t ins_e;
  int     ins_p;
  always @(posedge clk) begin
    if (sort_clear) chain.delete();
    if (sort_en) begin
      ins_e = '{llr: sort_LLR, q: sort_Q, idx_a: sort_IndexA, idx_i: sort_IndexI};
      ins_p = 0;
      while (ins_p < chain.size() && chain[ins_p].llr <= ins_e.llr) ins_p++;
      chain.insert(ins_p, ins_e);
    end
    if (sort_shift && chain.size() > 0) void'(chain.pop_front());
    head_e <= (chain.size() > 0) ? chain[0] : CLEARED;
  end

  // ---------------- scoreboard ----------------
  entry_t exp_e[$];
  logic   exp_last[$];
  int     exp_err_total = 0;

  // Reference: the Out_Num smallest LLRs in ascending order, padded with the
  // cleared value when the frame is short.
  task automatic push_expected(input entry_t fr[$]);
    entry_t rem[$];
    int     best;
    rem = fr;
    for (int k = 0; k < ON; k++) begin
      if (rem.size() == 0) begin
        exp_e.push_back(CLEARED);
      end else begin
        best = 0;
        for (int j = 1; j < rem.size(); j++)
          if (rem[j].llr < rem[best].llr) best = j;
        exp_e.push_back(rem[best]);
        rem.delete(best);
      end
      exp_last.push_back(k == ON - 1);
    end
  endtask

  // ---------------- monitor ----------------
  int     cyc = 0;
  int     sen_cnt = 0, last_sen = 0, ov_rise = 0, err_cnt = 0, pop_cnt = 0;
  int     turn_step = 0, turn_seen = 0;
  logic   ov_prev = 1'b0, stall_prev = 1'b0;
  logic [$bits(entry_t):0] held;
  entry_t got, want;
  logic   want_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
      ov_prev    = 1'b0;
      turn_step  = 0;
    end else begin
      if (sort_en || sort_shift || sort_clear)
        chk("strobe exclusive", {63'd0, (sort_en && sort_shift) || (sort_clear && (sort_en || sort_shift))}, 64'd0);
      if (stall_prev && out_valid)
        chk("hold while stalled", {out_LLR, out_Q, out_IndexA, out_IndexI, out_last}, held);
      if (turn_step == 2) begin
        chk("turnaround in_ready", {63'd0, in_ready}, 64'd1);
        turn_step = 0;
        turn_seen++;
      end else if (turn_step == 1) begin
        chk("turnaround clear cycle", {62'd0, sort_clear, in_ready}, 64'd2);
        turn_step = 2;
      end
      if (out_valid && out_ready) begin
        got = '{llr: out_LLR, q: out_Q, idx_a: out_IndexA, idx_i: out_IndexI};
        if (exp_e.size() == 0) begin
          chk("unexpected output", {63'd0, out_valid}, 64'd0);
        end else begin
          want      = exp_e.pop_front();
          want_last = exp_last.pop_front();
          chk("out entry", got, want);
          chk("out_last", {63'd0, out_last}, {63'd0, want_last});
        end
        pop_cnt++;
        if (out_last && in_valid) turn_step = 1;
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_LLR, out_Q, out_IndexA, out_IndexI, out_last};
      if (sort_en) begin
        sen_cnt++;
        last_sen = cyc;
      end
      if (out_valid && !ov_prev) ov_rise = cyc;
      ov_prev = out_valid;
      if (frame_err) err_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  bit rand_rdy = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_rdy ? 1'($urandom % 2) : 1'b1;
    end
  end

  task automatic make_frame(input int n, input bit desc, output entry_t fr[$]);
    int pool[$];
    int j, tmp;
    fr.delete();
    for (int i = 0; i < 63; i++) pool.push_back(i);
    for (int i = 0; i < n; i++) begin
      j = int'($urandom_range(i, 62));
      tmp = pool[i]; pool[i] = pool[j]; pool[j] = tmp;
      fr.push_back('{llr:   desc ? (LLR_Width+1)'(FL - 1 - i) : (LLR_Width+1)'(pool[i]),
                     q:     (Q_Width+1)'($urandom),
                     idx_a: (IndexA_Width+1)'($urandom),
                     idx_i: (IndexI_Width+1)'($urandom)});
    end
  endtask

  task automatic send_frame(input entry_t fr[$], input bit with_last, input bit rand_gap,
                            input bit keep_valid, input int stop_after);
    int t;
    for (int i = 0; i < fr.size(); i++) begin
      if (rand_gap && ($urandom % 3 == 0)) begin
        in_valid = 1'b0;
        repeat (int'($urandom_range(1, 2))) @(posedge clk);
        #1;
      end
      in_valid  = 1'b1;
      in_LLR    = fr[i].llr;
      in_Q      = fr[i].q;
      in_IndexA = fr[i].idx_a;
      in_IndexI = fr[i].idx_i;
      in_last   = with_last && (i == fr.size() - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 3000) begin
          chk("in_ready timeout", 64'd0, 64'd1);
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
      if (i + 1 == stop_after) return;
    end
    in_last = 1'b0;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit desc, input bit with_last,
                           input bit rand_gap, input bit keep_valid);
    entry_t fr[$];
    make_frame(n, desc, fr);
    push_expected(fr);
    if (with_last != (n == FL)) exp_err_total++;
    send_frame(fr, with_last, rand_gap, keep_valid, 0);
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while (exp_e.size() > 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 64'(exp_e.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " frame_err count"}, 64'(err_cnt), 64'(exp_err_total));
  endtask

  task automatic check_reset_outputs(input string nm);
    chk(nm, {in_ready, sort_clear, sort_en, sort_shift, out_valid, out_last, frame_err,
             sort_LLR, sort_Q, sort_IndexA, sort_IndexI}, 64'd0);
  endtask

  initial begin
    entry_t fr[$];
    int s0, t, base;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset state");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // 32 descending LLRs, in_last on the 32nd
    s0 = sen_cnt;
    run_frame(FL, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain("desc frame");
    chk("sort_en cycles", 64'(sen_cnt - s0), 64'(FL));
    chk("flush latency", 64'(ov_rise - last_sen), 64'(FC));

    // short frame: padded tail and one frame_err
    run_frame(10, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("short frame");

    // full frame without in_last: ends by count, flags mismatch
    run_frame(FL, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_drain("no-last frame");

    // random sizes, random input gaps, random out_ready stalls
    rand_rdy = 1'b1;
    for (int f = 0; f < 6; f++) begin
      run_frame(int'($urandom_range(2, FL)), 1'b0, 1'b1, 1'b1, 1'b0);
      wait_drain("random frame");
    end
    rand_rdy = 1'b0;

    // back-to-back with in_valid held high across the turnaround
    t = turn_seen;
    run_frame(20, 1'b0, 1'b1, 1'b0, 1'b1);
    run_frame(FL, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("back-to-back");
    chk("turnaround observed", 64'(turn_seen - t), 64'd1);

    // reset after 7 accepts in LOAD
    make_frame(20, 1'b0, fr);
    send_frame(fr, 1'b1, 1'b0, 1'b0, 7);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset mid-LOAD");
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(12, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("after LOAD reset");

    // reset after 3 outputs in DRAIN
    base = pop_cnt;
    run_frame(20, 1'b0, 1'b1, 1'b0, 1'b0);
    t = 0;
    while (pop_cnt < base + 3 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain start timeout", 64'(pop_cnt - base), 64'd3);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset mid-DRAIN");
    exp_e.delete();
    exp_last.delete();
    @(negedge clk);
    reset_n = 1'b1;
    run_frame(FL, 1'b0, 1'b1, 1'b0, 1'b0);
    wait_drain("after DRAIN reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
